// File: rtl/rice_decoder.sv
// Streaming Rice decoder: one serial bit per cycle in, zigzag-unfolded signed residual out.
// Codeword = unary run of 0s (quotient), a stop 1, then k remainder bits MSB-first.
module rice_decoder #(
  parameter int WIDTH   = 16,
  parameter int PARAM_W = 4
) (
  input  logic                    iClock,
  input  logic                    iReset,
  input  logic                    iValid,
  input  logic                    iBit,
  input  logic [PARAM_W-1:0]      iRiceParam,
  output logic signed [WIDTH-1:0] oSample,
  output logic                    oValid,
  output logic                    oError,
  output logic                    oBusy
);

  typedef enum logic {UNARY, BINARY} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [PARAM_W-1:0] cnt_q, cnt_d;
  logic [PARAM_W-1:0] k_q, k_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   sample_q, sample_d;
  logic               valid_q, valid_d;
  logic               error_q, error_d;

  logic [PARAM_W-1:0] k_eff;
  logic [WIDTH:0]     quot_max;
  logic [WIDTH-1:0]   u;
  logic               emit;

  // k comes straight from the port on a codeword's first bit, from the latch afterwards.
  assign k_eff    = busy_q ? k_q : iRiceParam;
  assign quot_max = ((WIDTH+1)'(1) << (WIDTH - int'(k_eff))) - (WIDTH+1)'(1);

  always_comb begin
    state_d  = state_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    busy_d   = busy_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    emit     = 1'b0;
    u        = '0;
    if (iValid) begin
      k_d    = k_eff;
      busy_d = 1'b1;
      case (state_q)
        UNARY: begin
          if (!iBit) begin
            if ({1'b0, quot_q} == quot_max) begin
              error_d = 1'b1;
              quot_d  = '0;
              busy_d  = 1'b0;
            end else begin
              quot_d = quot_q + 1'b1;
            end
          end else if (k_eff == '0) begin
            emit = 1'b1;
            u    = quot_q;
          end else begin
            state_d = BINARY;
            cnt_d   = k_eff;
          end
        end
        BINARY: begin
          rem_d = {rem_q[WIDTH-2:0], iBit};
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == PARAM_W'(1)) begin
            emit = 1'b1;
            u    = (quot_q << k_q) | rem_d;
          end
        end
        default: state_d = UNARY;
      endcase
      if (emit) begin
        valid_d  = 1'b1;
        sample_d = {1'b0, u[WIDTH-1:1]} ^ {WIDTH{u[0]}};
        quot_d   = '0;
        rem_d    = '0;
        cnt_d    = '0;
        state_d  = UNARY;
        busy_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q  <= UNARY;
      quot_q   <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      k_q      <= '0;
      busy_q   <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign oSample = sample_q;
  assign oValid  = valid_q;
  assign oError  = error_q;
  assign oBusy   = busy_q;

endmodule

// File: tb/tb_rice_decoder.sv
// Scoreboard bench for rice_decoder: directed codewords push expected results,
// a negedge monitor pops and checks each oValid/oError pulse and its timing.
module tb_rice_decoder;

  logic               iClock = 1'b0;
  logic               iReset = 1'b1;
  logic               iValid = 1'b0;
  logic               iBit   = 1'b0;
  logic [3:0]         iRiceParam = '0;
  logic signed [15:0] oSample;
  logic               oValid, oError, oBusy;

  rice_decoder #(.WIDTH(16), .PARAM_W(4)) dut (
    .iClock(iClock), .iReset(iReset), .iValid(iValid), .iBit(iBit),
    .iRiceParam(iRiceParam), .oSample(oSample), .oValid(oValid),
    .oError(oError), .oBusy(oBusy)
  );

  always #5 iClock = ~iClock;

  typedef struct {
    bit                 err;
    logic signed [15:0] s;
    int                 cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge iClock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every output pulse must match the head of the scoreboard, on time.
  always @(negedge iClock) begin
    if (!iReset) begin
      if (oValid || oError) begin
        check("valid_error_exclusive", int'(oValid && oError), 0);
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: oValid=%0d oError=%0d oSample=%0d", oValid, oError, oSample);
        end else begin
          exp_t e;
          e = q.pop_front();
          n_checks--;
          check("pulse_kind_error", int'(oError), int'(e.err));
          check("pulse_cycle", cyc, e.cyc);
          if (!e.err) check("sample", int'(oSample), int'(e.s));
        end
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
        exp_t e;
        e = q.pop_front();
        check("missing_pulse_err", 0, int'(e.err) + 1);
      end
    end
  end

  task automatic send_bit(input logic b, input int k);
    iValid = 1'b1; iBit = b; iRiceParam = 4'(k);
    @(posedge iClock); #1;
    iValid = 1'b0;
  endtask

  // Send n bits MSB-first; first bit carries k0, later bits carry k1.
  task automatic cw(input logic [31:0] bits, input int n, input int k0, input int k1,
                    input int exp_s, input bit err, input int gap);
    exp_t e;
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(bits[i], (i == n - 1) ? k0 : k1);
      if (i == 0) begin
        e.err = err; e.s = 16'(exp_s); e.cyc = cyc;
        q.push_back(e);
      end else begin
        for (int g = 0; g < gap; g++) begin
          @(negedge iClock);
          check("busy_in_gap", int'(oBusy), 1);
          @(posedge iClock); #1;
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge iClock);
    #1 iReset = 1'b0;
    @(negedge iClock);
    check("reset_sample", int'(oSample), 0);
    check("reset_valid", int'(oValid), 0);
    check("reset_error", int'(oError), 0);
    check("reset_busy", int'(oBusy), 0);
    @(posedge iClock); #1;

    // k=0 back-to-back
    cw(32'b1, 1, 0, 0, 0, 0, 0);
    @(negedge iClock);
    check("busy_single_bit_cw", int'(oBusy), 0);
    @(posedge iClock); #1;
    cw(32'b01, 2, 0, 0, -1, 0, 0);
    cw(32'b0000001, 7, 0, 0, 3, 0, 0);

    cw(32'b000101, 6, 2, 2, -7, 0, 0);
    cw(32'b0011000, 7, 4, 4, 20, 0, 0);

    // iValid gaps
    cw(32'b000101, 6, 2, 2, -7, 0, 3);

    // overflow at k=15, then max value
    cw(32'b00, 2, 15, 15, 0, 1, 0);
    @(negedge iClock);
    check("busy_after_error", int'(oBusy), 0);
    @(posedge iClock); #1;
    cw({15'd0, 2'b01, 15'h7fff}, 17, 15, 15, -32768, 0, 0);

    // k changes mid-codeword is ignored; next codeword uses the new k
    cw(32'b000101, 6, 2, 5, -7, 0, 0);
    cw(32'b100011, 6, 5, 5, -2, 0, 0);

    repeat (3) @(posedge iClock);
    @(negedge iClock);
    check("sample_hold", int'(oSample), -2);
    check("valid_idle", int'(oValid), 0);
    @(posedge iClock); #1;

    // reset mid-codeword
    send_bit(1'b0, 2); send_bit(1'b0, 2); send_bit(1'b1, 2); send_bit(1'b0, 2);
    iReset = 1'b1;
    @(posedge iClock); #1;
    iReset = 1'b0;
    @(negedge iClock);
    check("midreset_sample", int'(oSample), 0);
    check("midreset_valid", int'(oValid), 0);
    check("midreset_busy", int'(oBusy), 0);
    @(posedge iClock); #1;
    cw(32'b110, 3, 2, 2, 1, 0, 0);

    repeat (4) @(posedge iClock);
    #1;
    check("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
